req_sched: RTL and testbench

Round-robin scheduler that shares one downstream resource among N asynchronous request lines. Each line is synchronized and rising-edge detected internally. Each edge is latched as a sticky pending request. Pending requests are granted one at a time through a start/done handshake, with a timeout watchdog. It sits between raw CPLD input pins and a single shared action engine.

---
 rtl/req_sched.sv | 122 ++++++++++++
 tb/tb_req_sched.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/req_sched.sv
// Round-robin scheduler: synchronizes N request lines, latches rising edges as
// sticky pending requests and issues them one at a time via start/done.
module req_sched #(
  parameter int N       = 4,
  parameter int IDX_W   = 2,
  parameter int TIMEOUT = 200
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req_async,
  input  logic             done,
  input  logic             clr_flags,
  output logic             start,
  output logic [IDX_W-1:0] sel,
  output logic             busy,
  output logic [N-1:0]     pending,
  output logic [N-1:0]     overrun,
  output logic             timeout
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

  state_t           state, state_nxt;
  logic [N-1:0]     s1, s2, prev, rise;
  logic [N-1:0]     grant_mask;
  logic [IDX_W-1:0] last, winner;
  logic [7:0]       cnt;
  logic             grant, to_set;

  // First set bit at or after from+1, wrapping modulo N.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N-1:0] req,
                                                input logic [IDX_W-1:0] from);
    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    int             off;
    int             idx;
    dbl = {req, req} >> (int'(from) + 1);
    rot = dbl[N-1:0];
    off = 0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) off = k;
    end
    idx = (int'(from) + 1 + off) % N;
    return IDX_W'(idx);
  endfunction

  // Two-flop synchronizer plus one history flop for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= '0;
      s2   <= '0;
      prev <= '0;
    end else begin
      s1   <= req_async;
      s2   <= s1;
      prev <= s2;
    end
  end

  assign rise   = s2 & ~prev;
  assign winner = rr_pick(pending, last);
  assign grant  = (state == IDLE) && (|pending);

  always_comb begin
    grant_mask = '0;
    for (int i = 0; i < N; i++) begin
      grant_mask[i] = grant && (winner == IDX_W'(i));
    end
  end

  always_comb begin
    state_nxt = state;
    to_set    = 1'b0;
    unique case (state)
      IDLE:  if (|pending) state_nxt = ISSUE;
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        if (done) begin
          state_nxt = IDLE;
        end else if (cnt == LAST_CNT) begin
          to_set    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign start = (state == ISSUE);
  assign busy  = (state != IDLE);

  // Grant bookkeeping, sticky flags and the wait watchdog
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      sel     <= '0;
      last    <= IDX_W'(N - 1);
      pending <= '0;
      overrun <= '0;
      timeout <= 1'b0;
      cnt     <= '0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        sel  <= winner;
        last <= winner;
      end
      // New edges win over both the grant clear and clr_flags.
      pending <= (pending & ~grant_mask) | rise;
      overrun <= (clr_flags ? '0 : overrun) | (rise & pending & ~grant_mask);
      timeout <= (timeout & ~clr_flags) | to_set;
      if (state == ISSUE) begin
        cnt <= '0;
      end else if (state == WAIT && !done && cnt != LAST_CNT) begin
        cnt <= cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_req_sched.sv
// Directed bench for req_sched: a cycle-level behavioural model checked every
// cycle, plus hand-computed expectations for latency, order and flags.
module tb_req_sched;
  localparam int N       = 4;
  localparam int IDX_W   = 2;
  localparam int TIMEOUT = 200;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic [N-1:0]     req_async = '0;
  logic             done = 1'b0;
  logic             clr_flags = 1'b0;
  logic             start, busy, timeout;
  logic [IDX_W-1:0] sel;
  logic [N-1:0]     pending, overrun;

  int errors = 0;
  int checks = 0;

  req_sched #(.N(N), .IDX_W(IDX_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .req_async(req_async), .done(done),
    .clr_flags(clr_flags), .start(start), .sel(sel), .busy(busy),
    .pending(pending), .overrun(overrun), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: input sample history, pending/overrun sets, and a phase number
  // (0 idle, 1 issue, p>=2 means wait cycle p-1 of the current grant).
  logic [N-1:0] m_h0 = '0, m_h1 = '0, m_h2 = '0;
  logic [N-1:0] m_pend = '0, m_ovr = '0;
  logic         m_to = 1'b0;
  int           m_phase = 0;
  int           m_last = N - 1;
  int           m_sel = 0;
  int           m_grants[$];

  always @(posedge clk or negedge rst_n) begin : model
    logic [N-1:0] rise, gm, ovs;
    int nxt, c, d, best;
    if (!rst_n) begin
      m_h0 = '0; m_h1 = '0; m_h2 = '0;
      m_pend = '0; m_ovr = '0; m_to = 1'b0;
      m_phase = 0; m_last = N - 1; m_sel = 0;
    end else begin
      rise = m_h1 & ~m_h2;
      gm   = '0;
      nxt  = m_phase;
      if (clr_flags) begin
        m_ovr = '0;
        m_to  = 1'b0;
      end
      if (m_phase == 0) begin
        if (m_pend != '0) begin
          c = 0; best = N + 1;
          for (int ch = 0; ch < N; ch++) begin
            d = (ch - m_last - 1 + 2 * N) % N;
            if (m_pend[IDX_W'(ch)] && d < best) begin best = d; c = ch; end
          end
          gm[IDX_W'(c)] = 1'b1;
          m_sel = c; m_last = c;
          m_grants.push_back(c);
          nxt = 1;
        end
      end else if (m_phase == 1) begin
        nxt = 2;
      end else if (done) begin
        nxt = 0;
      end else if (m_phase - 1 == TIMEOUT) begin
        m_to = 1'b1;
        nxt  = 0;
      end else begin
        nxt = m_phase + 1;
      end
      ovs    = rise & m_pend & ~gm;
      m_ovr  = m_ovr | ovs;
      m_pend = (m_pend & ~gm) | rise;
      m_phase = nxt;
      m_h2 = m_h1; m_h1 = m_h0; m_h0 = req_async;
    end
  end

  always @(negedge clk) begin
    chk("cyc_start",   32'(start),   32'(m_phase == 1));
    chk("cyc_busy",    32'(busy),    32'(m_phase != 0));
    chk("cyc_sel",     32'(sel),     32'(m_sel));
    chk("cyc_pending", 32'(pending), 32'(m_pend));
    chk("cyc_overrun", 32'(overrun), 32'(m_ovr));
    chk("cyc_timeout", 32'(timeout), 32'(m_to));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_start(input int ch, input string nm, output int n);
    n = 0;
    while (start !== 1'b1 && n < 500) begin
      tick();
      n++;
    end
    chk({nm, "_seen"}, 32'(n < 500), 32'd1);
    chk({nm, "_sel"},  32'(sel),     32'(ch));
  endtask

  task automatic finish_job(input int dly);
    repeat (dly) tick();
    done = 1'b1;
    tick();
    done = 1'b0;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, blen;
    #1;
    rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_start",   32'(start),   32'd0);
    chk("rst_busy",    32'(busy),    32'd0);
    chk("rst_sel",     32'(sel),     32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_flags",   32'({overrun, timeout}), 32'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Single request on channel 2: 4 edges from drive to start.
    req_async = 4'b0100;
    wait_start(2, "t1", n);
    chk("t1_latency", 32'(n), 32'd4);
    chk("t1_busy", 32'(busy), 32'd1);
    finish_job(4);
    chk("t1_busy_after", 32'(busy), 32'd0);
    chk("t1_pend_after", 32'(pending), 32'd0);

    // Simultaneous 0,1,3 after reset, ch0 re-raised during grant of ch1.
    req_async = '0;
    reset_dut();
    req_async = 4'b1011;
    wait_start(0, "t3a", n);
    finish_job(2);
    req_async = '0;
    wait_start(1, "t3b", n);
    tick();
    req_async = 4'b0001;
    finish_job(1);
    wait_start(3, "t3c", n);
    finish_job(2);
    wait_start(0, "t3d", n);
    finish_job(2);
    chk("t3_grant_count", 32'(m_grants.size()), 32'd5);
    chk("t3_seq1", 32'(m_grants[1]), 32'd0);
    chk("t3_seq2", 32'(m_grants[2]), 32'd1);
    chk("t3_seq3", 32'(m_grants[3]), 32'd3);
    chk("t3_seq4", 32'(m_grants[4]), 32'd0);

    // Double edge on ch1 while ch0 is busy: overrun, single grant.
    req_async = '0;
    repeat (4) tick();
    req_async = 4'b0001;
    wait_start(0, "t4a", n);
    req_async = 4'b0011; repeat (3) tick();
    req_async = 4'b0001; repeat (3) tick();
    req_async = 4'b0011; repeat (3) tick();
    chk("t4_pend1", 32'(pending[1]), 32'd1);
    chk("t4_ovr1",  32'(overrun[1]), 32'd1);
    finish_job(1);
    wait_start(1, "t4b", n);
    finish_job(2);
    repeat (10) tick();
    chk("t4_no_regrant", 32'(busy), 32'd0);
    chk("t4_pend_empty", 32'(pending), 32'd0);
    clr_flags = 1'b1; tick(); clr_flags = 1'b0;
    chk("t4_ovr_clr", 32'(overrun), 32'd0);

    // Timeout on ch2 with ch3 queued.
    req_async = '0;
    repeat (4) tick();
    req_async = 4'b0100;
    wait_start(2, "t5a", n);
    req_async = 4'b1100;
    blen = 1;
    while (busy === 1'b1 && blen < 1000) begin
      tick();
      if (busy === 1'b1) blen++;
    end
    chk("t5_busy_len", 32'(blen), 32'(TIMEOUT + 1));
    chk("t5_timeout", 32'(timeout), 32'd1);
    wait_start(3, "t5b", n);
    finish_job(1);
    clr_flags = 1'b1; tick(); clr_flags = 1'b0;
    chk("t5_to_clr", 32'(timeout), 32'd0);

    // done on the final wait cycle is a success.
    req_async = '0;
    repeat (4) tick();
    req_async = 4'b0001;
    wait_start(0, "t6", n);
    finish_job(TIMEOUT);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_no_timeout", 32'(timeout), 32'd0);

    // Async reset mid-wait with ch1 pending, ch1 held high through release.
    req_async = '0;
    repeat (4) tick();
    req_async = 4'b0100;
    wait_start(2, "t7a", n);
    req_async = 4'b0010;
    repeat (5) tick();
    chk("t7_pend_before", 32'(pending), 32'b0010);
    #1 rst_n = 1'b0;
    #1;
    chk("t7_start", 32'(start),   32'd0);
    chk("t7_busy",  32'(busy),    32'd0);
    chk("t7_pend",  32'(pending), 32'd0);
    chk("t7_sel",   32'(sel),     32'd0);
    chk("t7_flags", 32'({overrun, timeout}), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    wait_start(1, "t7b", n);
    finish_job(1);
    repeat (10) tick();
    chk("t7_single", 32'(busy), 32'd0);
    chk("t7_pend_end", 32'(pending), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
